// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame layout and controller state encoding.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;
    localparam int DATA_MSB   = 7;
    localparam int DATA_LSB   = 0;

    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    // Assemble {rw, addr, data} into frame bit order.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic       rw,
        input logic [6:0] addr,
        input logic [7:0] data
    );
        logic [FRAME_BITS-1:0] f;
        f                     = {FRAME_BITS{1'b0}};
        f[RW_BIT]             = (rw == RW_WRITE);
        f[ADDR_MSB:ADDR_LSB]  = addr;
        f[DATA_MSB:DATA_LSB]  = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period tick generator: one-cycle tick every CLK_DIV cycles while enabled.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Free-running 0..CLK_DIV-1 counter, held at zero while disabled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends one 16-bit {rw, addr, wdata} frame MSB first and
// captures the last 8 CIPO bits into rdata.
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    input  logic       cipo
);

    import spi_pkg::*;

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    spi_state_e            state_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [7:0]            cap_r;
    logic [3:0]            bit_cnt_r;
    logic                  tick_s;
    logic                  en_s;

    assign en_s = (state_r != IDLE);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (en_s),
        .tick (tick_s)
    );

    // copi is the MSB of the shift register; clearing the register idles the line low.
    assign copi = shift_r[FRAME_BITS-1];

    // Frame sequencer: every phase lasts one divider period; bit_cnt_r is the bit on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            shift_r   <= {FRAME_BITS{1'b0}};
            cap_r     <= 8'h00;
            bit_cnt_r <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= 8'h00;
            sclk      <= 1'b0;
            ncs       <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shift_r   <= pack_frame(rw, addr, wdata);
                        bit_cnt_r <= 4'd0;
                        busy      <= 1'b1;
                        ncs       <= 1'b0;
                        state_r   <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick_s) begin
                        sclk    <= 1'b1;
                        cap_r   <= {cap_r[6:0], cipo};
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick_s) begin
                        if (sclk) begin
                            sclk <= 1'b0;
                            if (bit_cnt_r != LAST_BIT) begin
                                shift_r <= {shift_r[FRAME_BITS-2:0], 1'b0};
                            end
                        end else if (bit_cnt_r == LAST_BIT) begin
                            state_r <= HOLD;
                        end else begin
                            sclk      <= 1'b1;
                            cap_r     <= {cap_r[6:0], cipo};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (tick_s) begin
                        ncs     <= 1'b1;
                        shift_r <= {FRAME_BITS{1'b0}};
                        state_r <= GAP;
                    end
                end
                GAP: begin
                    if (tick_s) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        rdata   <= cap_r;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    shift_r <= {FRAME_BITS{1'b0}};
                    busy    <= 1'b0;
                    sclk    <= 1'b0;
                    ncs     <= 1'b1;
                end
            endcase
        end
    end

endmodule
